fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder and immediate extender.
- Keeps the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing buffered words and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch FIFO entries; also the maximum of outstanding requests plus buffered words; power of 2, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- imemReqValid  output  1  fetch request valid.
- imemReqReady  input  1  memory accepts the request this cycle.
- imemReqAddr  output  32  word address of the request; bits [1:0] are always 0.
- imemRspValid  input  1  response data valid; responses arrive in order, at least 1 cycle after acceptance.
- imemRspData  input  32  returned instruction word.
- redirectValid  input  1  taken branch/jump/trap redirect, one-cycle pulse.
- redirectPc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
- decReady  input  1  decode accepts the head word.
- decValid  output  1  FIFO head is valid.
- decInstr  output  32  head instruction; NOP 32'h00000013 when the FIFO is empty.
- decPc  output  32  PC of the head instruction; 0 when the FIFO is empty.
- decPcPlus4  output  32  decPc + 4, wrapping modulo 2^32.

Behaviour:
- Reset (rstn low, async) sets:
  - fetchPc = RESET_PC, rspPc = RESET_PC.
  - outstanding = 0, dropCount = 0, FIFO count = 0.
  - imemReqValid = 0, decValid = 0, decInstr = NOP, decPc = 0.
  - FSM state = BOOT.
- FSM:
  - BOOT lasts 1 cycle after reset deassertion with no requests, then goes to RUN.
  - RUN stays in RUN; any redirect keeps the FSM in RUN.
  - Reset mid-operation returns to BOOT immediately and abandons in-flight responses.
- Request issue (RUN only):
  - imemReqValid = !redirectValid && (outstanding + count < FIFO_DEPTH).
  - imemReqAddr = fetchPc.
  - On handshake: fetchPc += 4 (wraps 0xFFFFFFFC -> 0x00000000) and outstanding++.
  - Credit rule guarantees FIFO space for every accepted response, so no response is ever lost for lack of space.
- Response capture:
  - If imemRspValid and dropCount > 0: discard the word, dropCount--, outstanding--.
  - Otherwise: push {imemRspData, rspPc}, rspPc += 4, outstanding--.
- Decode side:
  - Head pops when decValid && decReady.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - Outputs are driven from registered FIFO storage, so data reaches decode 1 cycle after the response is written.
- Redirect (redirectValid = 1):
  - Next cycle: fetchPc = rspPc = {redirectPc[31:2], 2'b00}.
  - FIFO count = 0; decValid drops next cycle.
  - dropCount = outstanding after this cycle's response update; all in-flight responses are discarded.
  - imemReqValid is forced low in the redirect cycle, so no old-path request is accepted.
  - A pop in the redirect cycle is still a valid consumption.
  - Simultaneous redirect and response: the response updates counters and is then ignored; the flush wins.
- Minimum redirect-to-first-request latency: 1 cycle.
- Widths:
  - outstanding and dropCount are $clog2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.
  - An imemRspValid with outstanding = 0 is a protocol error; it is ignored and flagged by a bench assertion.

Decomposition:
- Shared package fetch_pkg holds:
  - RESET_PC default.
  - NOP_INSTR = 32'h00000013.
  - Fetch-entry struct {instr[31:0], pc[31:0]}.
  - FSM state enum {BOOT, RUN}.
- One sub-module, fetch_fifo:
  - Synchronous FIFO of fetch entries, DEPTH parameter.
  - Ports: push, pop, flush, count, head.
  - Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then memory ready always with 1-cycle latency, decReady = 1 -> requests at 0x0, 0x4, 0x8...; decPc sequence 0x0, 0x4, 0x8; decPcPlus4 = decPc + 4; decInstr matches memory.
- decReady = 0 for 10 cycles -> exactly 2 requests accepted, then imemReqValid stays 0; FIFO holds 0x0 and 0x4; after release they drain in order with no loss.
- With 2 requests outstanding, redirectPc = 0x100 -> both old responses dropped; next request addr 0x100; first decPc = 0x100.
- Redirect in the same cycle as a response and a decode pop -> popped word counted once; FIFO empty next cycle; no stale word reaches decode.
- redirectPc = 0xFFFFFFFE -> fetch at 0xFFFFFFFC, then 0x00000000; decPcPlus4 of 0xFFFFFFFC = 0x0.
- rstn asserted mid-stream with 2 responses in flight -> all outputs at reset values immediately; one BOOT cycle; then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch stage, instruction memory, redirect source and decode.
// Handshakes: a transfer happens in a cycle where valid and ready are both high at the
// rising edge; payload is stable while valid is high. Responses have no ready (always taken).
interface fetch_if;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        decReady;
  logic        decValid;
  logic [31:0] decInstr;
  logic [31:0] decPc;
  logic [31:0] decPcPlus4;

  modport master (
    output imemReqValid, imemReqAddr, decValid, decInstr, decPc, decPcPlus4,
    input  imemReqReady, imemRspValid, imemRspData, redirectValid, redirectPc, decReady
  );

  modport slave (
    input  imemReqValid, imemReqAddr, decValid, decInstr, decPc, decPcPlus4,
    output imemReqReady, imemRspValid, imemRspData, redirectValid, redirectPc, decReady
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push_i && (cnt_q != DEPTH_C) && !flush_i;
    do_pop   = pop_i && (cnt_q != '0) && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only observed while cnt_q covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response capture,
// prefetch buffering and redirect flush with in-flight response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstn,
  fetch_if.master    bus,
  output logic [0:0] dbg_state_o
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [0:0]    ST_BOOT = BOOT;
  localparam logic [0:0]    ST_RUN  = RUN;

  logic [0:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count;
  logic [CW:0]   inflight;
  logic [31:0]   target_pc;
  logic          req_valid, req_fire, rsp_fire, rsp_drop, push, pop, dec_valid;
  fetch_entry_t  head, push_entry;

  assign dec_valid = (count != '0);
  assign pop       = dec_valid && bus.decReady;
  assign target_pc = word_align(bus.redirectPc);
  assign inflight  = {1'b0, out_q} + {1'b0, count};

  always_comb begin
    req_valid  = (state_q == ST_RUN) && !bus.redirectValid && (inflight < DEPTH_W);
    req_fire   = req_valid && bus.imemReqReady;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_fire   = bus.imemRspValid && (out_q != '0);
    rsp_drop   = rsp_fire && (drop_q != '0);
    push       = rsp_fire && !rsp_drop && !bus.redirectValid;
    push_entry = '{instr: bus.imemRspData, pc: rsp_pc_q};

    out_d      = out_q + CW'(req_fire) - CW'(rsp_fire);
    drop_d     = drop_q - CW'(rsp_drop);
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)     rsp_pc_d   = rsp_pc_q + 32'd4;
    // Everything still in flight after this cycle belongs to the old path.
    if (bus.redirectValid) begin
      drop_d     = out_d;
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
    end

    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rstn),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (bus.redirectValid),
    .count_o      (count),
    .head_o       (head)
  );

  assign bus.imemReqValid = req_valid;
  assign bus.imemReqAddr  = fetch_pc_q;
  assign bus.decValid     = dec_valid;
  assign bus.decInstr     = dec_valid ? head.instr : NOP_INSTR;
  assign bus.decPc        = dec_valid ? head.pc : 32'h0;
  assign bus.decPcPlus4   = bus.decPc + 32'd4;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode/redirect stimulus checked every cycle
// against a queue-based model of what decode and the memory port must see.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          rel;
  } mem_req_t;

  logic       clk;
  logic       rstn;
  logic [0:0] dbg_state;
  fetch_if    f ();

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (f),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // memory model
  mem_req_t    mem_q[$];
  bit          mem_hold = 0;
  int          mem_lat  = 0;

  // reference model: exp_q holds the PCs decode must see, head first
  logic [31:0] exp_q[$];
  logic [31:0] m_fetch_pc, m_rsp_pc;
  int          m_out, m_drop;
  bit          m_boot;

  // observation logs
  logic [31:0] acc_q[$];
  logic [31:0] pop_q[$];
  bit          collide_arm = 0, collide_hit = 0;
  logic [31:0] collide_pc  = 32'h200;
  bit          wrap_seen   = 0;
  logic [31:0] wrap_p4     = 32'hDEAD_BEEF;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mem_q.delete();
    m_fetch_pc = RST_PC;
    m_rsp_pc   = RST_PC;
    m_out      = 0;
    m_drop     = 0;
    m_boot     = 1;
  endtask

  // Called at a negedge; asserts reset dly time units later, checks reset outputs,
  // releases at a later negedge.
  task automatic do_reset(input int dly);
    #(dly);
    f.redirectValid = 1'b0;
    f.redirectPc    = '0;
    f.imemRspValid  = 1'b0;
    f.imemRspData   = '0;
    f.imemReqReady  = 1'b0;
    f.decReady      = 1'b0;
    rstn            = 1'b0;
    #1;
    chk("rst_req_valid", f.imemReqValid, 0);
    chk("rst_dec_valid", f.decValid, 0);
    chk("rst_dec_instr", f.decInstr, 32'h0000_0013);
    chk("rst_dec_pc", f.decPc, 32'h0);
    chk("rst_dec_pc4", f.decPcPlus4, 32'h4);
    chk("rst_state", dbg_state, BOOT);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // driver: one full cycle, entered and left at a negedge
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit dready, input bit mready);
    bit          rsp_v, m_req, fire, pop, rsp_take;
    logic [31:0] exp_pc;
    logic [0:0]  exp_st;
    rsp_v = 0;
    if (!mem_hold && mem_q.size() > 0 && mem_q[0].rel <= cyc) rsp_v = 1;
    if (collide_arm && rsp_v && exp_q.size() > 0 && dready) begin
      redir       = 1;
      rpc         = collide_pc;
      collide_arm = 0;
      collide_hit = 1;
    end
    f.redirectValid = redir;
    f.redirectPc    = rpc;
    f.decReady      = dready;
    f.imemReqReady  = mready;
    f.imemRspValid  = rsp_v;
    f.imemRspData   = rsp_v ? mem_word(mem_q[0].addr) : 32'h0;
    if (rsp_v) assert (m_out != 0) else $error("protocol error: response with nothing outstanding");
    #1;

    // compare DUT against model
    m_req  = !m_boot && !redir && (m_out + exp_q.size() < DEPTH);
    exp_pc = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
    exp_st = m_boot ? BOOT : RUN;
    chk("req_valid", f.imemReqValid, m_req);
    if (m_req) chk("req_addr", f.imemReqAddr, m_fetch_pc);
    chk("dec_valid", f.decValid, exp_q.size() > 0);
    chk("dec_pc", f.decPc, exp_pc);
    chk("dec_instr", f.decInstr, (exp_q.size() > 0) ? mem_word(exp_pc) : NOP_INSTR);
    chk("dec_pc4", f.decPcPlus4, exp_pc + 32'd4);
    chk("state", dbg_state, exp_st);

    // memory side and logs
    if (rsp_v) void'(mem_q.pop_front());
    if (f.imemReqValid && mready) begin
      mem_q.push_back('{addr: f.imemReqAddr, rel: cyc + 1 + $urandom_range(0, mem_lat)});
      acc_q.push_back(f.imemReqAddr);
    end
    if (f.decValid && dready) pop_q.push_back(f.decPc);
    if (f.decValid && f.decPc == 32'hFFFF_FFFC) begin
      wrap_seen = 1;
      wrap_p4   = f.decPcPlus4;
    end

    // model update for this edge
    fire     = m_req && mready;
    pop      = (exp_q.size() > 0) && dready;
    rsp_take = rsp_v && (m_out != 0);
    if (pop) void'(exp_q.pop_front());
    if (rsp_take) begin
      if (m_drop > 0) m_drop--;
      else if (!redir) begin
        exp_q.push_back(m_rsp_pc);
        m_rsp_pc += 32'd4;
      end
    end
    m_out = m_out + int'(fire) - int'(rsp_take);
    if (redir) begin
      exp_q.delete();
      m_fetch_pc = rpc & 32'hFFFF_FFFC;
      m_rsp_pc   = rpc & 32'hFFFF_FFFC;
      m_drop     = m_out;
    end else if (fire) begin
      m_fetch_pc += 32'd4;
    end
    m_boot = 0;

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn            = 1'b1;
    f.redirectValid = 1'b0;
    f.redirectPc    = '0;
    f.imemRspValid  = 1'b0;
    f.imemRspData   = '0;
    f.imemReqReady  = 1'b0;
    f.decReady      = 1'b0;
    model_reset();
    @(negedge clk);

    // streaming with 1-cycle memory, decode always ready
    do_reset(0);
    acc_q.delete(); pop_q.delete();
    mem_lat = 0;
    repeat (20) cycle(0, 0, 1, 1);
    chk("t1_acc0", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF, 32'h0);
    chk("t1_acc1", (acc_q.size() > 1) ? acc_q[1] : 32'hDEAD_BEEF, 32'h4);
    chk("t1_acc2", (acc_q.size() > 2) ? acc_q[2] : 32'hDEAD_BEEF, 32'h8);
    chk("t1_pop0", (pop_q.size() > 0) ? pop_q[0] : 32'hDEAD_BEEF, 32'h0);
    chk("t1_pop1", (pop_q.size() > 1) ? pop_q[1] : 32'hDEAD_BEEF, 32'h4);
    chk("t1_pop2", (pop_q.size() > 2) ? pop_q[2] : 32'hDEAD_BEEF, 32'h8);

    // decode stalled: only FIFO_DEPTH requests may be accepted
    do_reset(0);
    acc_q.delete(); pop_q.delete();
    repeat (10) cycle(0, 0, 0, 1);
    chk("t2_acc_count", acc_q.size(), 2);
    chk("t2_head_pc", f.decPc, 32'h0);
    repeat (6) cycle(0, 0, 1, 1);
    chk("t2_pop0", (pop_q.size() > 0) ? pop_q[0] : 32'hDEAD_BEEF, 32'h0);
    chk("t2_pop1", (pop_q.size() > 1) ? pop_q[1] : 32'hDEAD_BEEF, 32'h4);

    // redirect with two requests in flight
    do_reset(0);
    acc_q.delete(); pop_q.delete();
    mem_hold = 1;
    repeat (3) cycle(0, 0, 1, 1);
    chk("t3_inflight", acc_q.size(), 2);
    acc_q.delete(); pop_q.delete();
    cycle(1, 32'h100, 1, 1);
    mem_hold = 0;
    repeat (10) cycle(0, 0, 1, 1);
    chk("t3_acc0", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF, 32'h100);
    chk("t3_pop0", (pop_q.size() > 0) ? pop_q[0] : 32'hDEAD_BEEF, 32'h100);

    // redirect coinciding with a response and a decode pop
    collide_arm = 1;
    collide_hit = 0;
    for (int i = 0; i < 20 && !collide_hit; i++) cycle(0, 0, 1, 1);
    chk("t4_collide_hit", collide_hit, 1);
    chk("t4_dec_valid_after", f.decValid, 0);
    collide_arm = 0;
    repeat (8) cycle(0, 0, 1, 1);

    // redirect near the top of the address space
    acc_q.delete(); pop_q.delete();
    wrap_seen = 0;
    cycle(1, 32'hFFFF_FFFE, 1, 1);
    repeat (12) cycle(0, 0, 1, 1);
    chk("t5_acc0", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("t5_acc1", (acc_q.size() > 1) ? acc_q[1] : 32'hDEAD_BEEF, 32'h0);
    chk("t5_wrap_seen", wrap_seen, 1);
    chk("t5_wrap_pc4", wrap_p4, 32'h0);

    // reset in the middle of a cycle with two responses in flight
    mem_hold = 1;
    repeat (4) cycle(0, 0, 1, 1);
    do_reset(2);
    mem_hold = 0;
    acc_q.delete(); pop_q.delete();
    repeat (8) cycle(0, 0, 1, 1);
    chk("t6_acc0", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF, RST_PC);
    chk("t6_pop0", (pop_q.size() > 0) ? pop_q[0] : 32'hDEAD_BEEF, RST_PC);

    // random traffic
    mem_lat = 2;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0);
    end
    mem_lat = 0;
    repeat (10) cycle(0, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
